// File: rtl/fp_norm_seq.sv
// rtl/fp_norm_seq.sv - iterative one-bit-per-cycle FP32 normalize-and-pack stage
module fp_norm_seq #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MANT_W:0]           in_sum,
    input  logic [EXP_W-1:0]          in_exp,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MANT_W+EXP_W-1:0]   out_res,
    output logic                      out_ovf,
    output logic                      out_unf
);

    // Working exponent carries two guard bits so carry increments past the max code are visible
    localparam int WE = EXP_W + 2;
    localparam logic [WE-1:0] EXP_MAX = WE'((1 << EXP_W) - 1);
    localparam logic [WE-1:0] EXP_ONE = WE'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_sign;
    logic [MANT_W:0]    r_mag;
    logic [WE-1:0]      r_exp;

    logic [MANT_W:0]    w_neg;
    logic [MANT_W:0]    w_mag;
    logic [WE-1:0]      w_exp_in;

    // Magnitude of the incoming two's-complement sum; -2^MANT_W maps onto the carry bit
    always_comb begin
        w_neg    = ~in_sum + {{MANT_W{1'b0}}, 1'b1};
        w_mag    = in_sum[MANT_W] ? w_neg : in_sum;
        w_exp_in = {2'b00, in_exp};
    end

    assign in_ready = (r_state == S_IDLE) & ~rst;

    // Accept, shift one bit per cycle until normalized/zero/underflow, then hold the result until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sign    <= 1'b0;
            r_mag     <= '0;
            r_exp     <= '0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign  <= in_sum[MANT_W];
                        r_mag   <= w_mag;
                        r_exp   <= w_exp_in;
                        out_ovf <= 1'b0;
                        out_unf <= 1'b0;
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (r_mag == '0) begin
                        // Exact cancellation always yields +0 regardless of operand signs
                        out_res   <= '0;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (r_mag[MANT_W]) begin
                        // Carry out of the adder: drop the LSB, rounding already happened upstream
                        r_mag <= r_mag >> 1;
                        r_exp <= r_exp + EXP_ONE;
                    end else if (r_mag[MANT_W-1]) begin
                        if (r_exp >= EXP_MAX) begin
                            out_res <= {r_sign, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
                            out_ovf <= 1'b1;
                        end else begin
                            out_res <= {r_sign, r_exp[EXP_W-1:0], r_mag[MANT_W-2:0]};
                        end
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (r_exp <= EXP_ONE) begin
                        // No subnormal support: flush to a signed zero
                        out_res   <= {r_sign, {(EXP_W+MANT_W-1){1'b0}}};
                        out_unf   <= 1'b1;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - EXP_ONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_norm_seq.sv
// tb/tb_fp_norm_seq.sv - directed scoreboard bench for fp_norm_seq
module tb_fp_norm_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_sum;
    logic [7:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic        out_ovf;
    logic        out_unf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        int          lat;
    } exp_t;

    exp_t sb[$];

    fp_norm_seq #(.MANT_W(24), .EXP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input string tag, input logic [24:0] s, input logic [7:0] e);
        @(negedge clk);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_sum   = s;
        in_exp   = e;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic collect(input string tag);
        exp_t x;
        int   cyc;
        int   busy_bad;
        cyc      = 1;
        busy_bad = 0;
        while (!out_valid && cyc < 200) begin
            if (in_ready) busy_bad++;
            @(posedge clk);
            #1 cyc++;
        end
        x = sb.pop_front();
        check({tag, "_valid"},    {31'b0, out_valid}, 32'd1);
        check({tag, "_busy"},     busy_bad, 32'd0);
        check({tag, "_latency"},  cyc, x.lat);
        check({tag, "_res"},      out_res, x.res);
        check({tag, "_ovf"},      {31'b0, out_ovf}, {31'b0, x.ovf});
        check({tag, "_unf"},      {31'b0, out_unf}, {31'b0, x.unf});
        check({tag, "_in_ready_done"}, {31'b0, in_ready}, 32'd0);
    endtask

    task automatic release_out(input string tag, input logic [31:0] res);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_idle_ready"}, {31'b0, in_ready}, 32'd1);
        check({tag, "_res_hold"},   out_res, res);
    endtask

    task automatic txn(input string tag, input logic [24:0] s, input logic [7:0] e,
                       input logic [31:0] res, input logic ovf, input logic unf, input int lat);
        sb.push_back('{res: res, ovf: ovf, unf: unf, lat: lat});
        drive(tag, s, e);
        collect(tag);
        release_out(tag, res);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_exp    = '0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",    {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready},  32'd0);
        check("rst_res",      out_res,            32'd0);
        check("rst_ovf",      {31'b0, out_ovf},   32'd0);
        check("rst_unf",      {31'b0, out_unf},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_ready", {31'b0, in_ready}, 32'd1);

        txn("norm_pos",  25'h0C00000, 8'h7F, 32'h3FC00000, 1'b0, 1'b0, 2);
        txn("neg",       25'h1400000, 8'h80, 32'hC0400000, 1'b0, 1'b0, 2);
        txn("carry",     25'h1000000, 8'h7F, 32'hC0000000, 1'b0, 1'b0, 3);
        txn("ovf",       25'h1000000, 8'hFE, 32'hFF800000, 1'b1, 1'b0, 3);
        txn("max_shift", 25'h0000001, 8'h7F, 32'h34000000, 1'b0, 1'b0, 25);
        txn("zero",      25'h0000000, 8'h90, 32'h00000000, 1'b0, 1'b0, 2);
        txn("unf_pos",   25'h0000100, 8'h03, 32'h00000000, 1'b0, 1'b1, 4);
        txn("unf_neg",   25'h1FFFF00, 8'h02, 32'h80000000, 1'b0, 1'b1, 3);
        txn("flag_clr",  25'h0C00000, 8'h7F, 32'h3FC00000, 1'b0, 1'b0, 2);

        // Backpressure: result must hold while the consumer stalls
        sb.push_back('{res: 32'hC0400000, ovf: 1'b0, unf: 1'b0, lat: 2});
        drive("bp", 25'h1400000, 8'h80);
        collect("bp");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_res",   out_res,            32'hC0400000);
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_ready", {31'b0, in_ready},  32'd0);
        end
        release_out("bp", 32'hC0400000);
        txn("bp_next", 25'h0000003, 8'h80, 32'h3FC00000 + 32'h00800000 - 32'h0B000000, 1'b0, 1'b0, 24);

        // Reset during a long left-shift run discards the in-flight sum
        drive("abort", 25'h0000001, 8'h7F);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_valid",    {31'b0, out_valid}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready},  32'd0);
        @(posedge clk);
        #1;
        check("abort_valid2",    {31'b0, out_valid}, 32'd0);
        check("abort_in_ready2", {31'b0, in_ready},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("abort_released_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        check("abort_no_stale", seen, 32'd0);
        txn("after_abort", 25'h0C00000, 8'h7F, 32'h3FC00000, 1'b0, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_norm_seq.md
# fp_norm_seq

Sequential normalize-and-pack stage for the FP32 adder datapath. It sits directly downstream of the add/round stage. It consumes the rounded 25-bit two's-complement sum and the large-operand exponent, and returns an IEEE-754 single-precision result. It replaces a single-cycle priority-encoder normalizer with an iterative one-bit-per-cycle shifter behind a valid/ready handshake on both sides.

## Interface
- MANT_W, default 24: significand width including the hidden bit. The input sum is MANT_W+1 bits.
- EXP_W, default 8: exponent width.
- clk  in  1: the single clock; all state updates on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- in_valid  in  1: the upstream stage presents a sum.
- in_ready  out  1: the block can accept a sum; equals (state==IDLE) & ~rst.
- in_sum  in  25: rounded sum, two's complement; bit 24 is the sign.
- in_exp  in  8: biased exponent of the larger operand.
- out_valid  out  1: out_res and the flags are valid.
- out_ready  in  1: the downstream consumer accepts the result.
- out_res  out  32: packed result {sign, exp[7:0], frac[22:0]}.
- out_ovf  out  1: the result saturated to infinity.
- out_unf  out  1: the result was flushed to zero.

## Operation
- **States:** IDLE, NORM, DONE. Reset forces IDLE, out_valid=0, out_res=0, out_ovf=0 and out_unf=0.
- **Accept (IDLE):** on in_valid & in_ready, register:
  - sign = in_sum[24];
  - mag[24:0] = sign ? (~in_sum + 1) : in_sum (25 bits, so -2^24 yields mag=25'h1000000);
  - exp_w = {2'b00, in_exp} as a 10-bit working exponent.
  - Then go to NORM.
- **NORM:** exactly one action per cycle, in this priority:
  1. mag==0 → result +0 (sign forced to 0), go DONE.
  2. mag[24]==1 → mag >>= 1 (truncate the LSB; rounding is done upstream), exp_w += 1, stay in NORM.
  3. mag[23]==1 → normalized, go DONE.
  4. exp_w <= 1 → underflow: result {sign, 31'b0}, set unf, go DONE. Subnormals are not produced.
  5. Otherwise → mag <<= 1, exp_w -= 1, stay in NORM.
- **Result selection on the NORM→DONE transition:**
  - exp_w >= 255 → out_res = {sign, 8'hFF, 23'h0}, out_ovf=1.
  - Normalized case otherwise → out_res = {sign, exp_w[7:0], mag[22:0]}.
  - out_res and the flags are registered on this transition.
- **DONE:**
  - out_valid=1. out_res and the flags are held stable until out_ready.
  - On out_valid & out_ready → IDLE, out_valid=0 on the next cycle.
  - out_res keeps its last value while in IDLE.
  - Flags clear on the next accept.
- **No overlap:** in_ready=0 in NORM and DONE. A new sum is never accepted in the same cycle a result is consumed; the earliest re-accept is the first IDLE cycle.
- **Reset mid-operation:** immediate return to IDLE. out_valid drops asynchronously and the in-flight sum is discarded.

## Timing
- Cycles are counted from the accept edge, E0.
- Already-normalized input or zero: DONE is entered at E1, so out_valid is high after E1 (latency 2).
- Carry case (mag[24]==1): one right shift, then normalized; out_valid after E2 (latency 3).
- k left shifts: latency 2+k. Worst case in_sum=1 gives k=23, latency 25.
- Underflow flush: latency 2 plus the number of left shifts performed before exp_w reached 1.
- Throughput: at most one result per latency+1 cycles (one IDLE cycle between transactions).

## Test plan
- **Normalized positive:** in_sum=25'h0C00000, in_exp=8'h7F → out_res=32'h3FC00000, flags 0, out_valid exactly 2 cycles after accept.
- **Negative, carry and overflow:**
  - in_sum=25'h1400000, in_exp=8'h80 → 32'hC0400000.
  - in_sum=25'h1000000, in_exp=8'h7F → 32'hC0000000 at latency 3.
  - in_sum=25'h1000000, in_exp=8'hFE → 32'hFF800000, out_ovf=1.
- **Maximum left shift:** in_sum=25'h0000001, in_exp=8'h7F → 32'h34000000, latency 25.
- **Zero and underflow:**
  - in_sum=0, in_exp=8'h90 → 32'h00000000, flags 0, latency 2.
  - in_sum=25'h0000100, in_exp=8'h03 → 32'h00000000, out_unf=1.
  - in_sum=25'h1FFFF00 (negative), in_exp=8'h02 → 32'h80000000, out_unf=1.
- **Backpressure:** hold out_ready=0 for 5 cycles after out_valid → out_res is stable and in_ready=0 throughout. Pulse out_ready → IDLE next cycle, and the next sum is accepted the cycle after.
- **Reset mid-NORM:** assert rst during a 23-shift operation → out_valid=0 and in_ready=0 during reset. After release, in_ready=1, no stale result appears, and a fresh 25'h0C00000 / 8'h7F transaction yields 32'h3FC00000.
